btn_debounce_edge: RTL and testbench

Conditions a raw, asynchronous push-button or switch level into a clean, clock-synchronous stimulus for the gate-level blocks (NOT, AND, OR …) on the study board. It synchronises the input, debounces it with a stability counter, and produces three outputs: a clean level, single-cycle rise/fall pulses, and a press-toggled level that drives a downstream gate input. An 8-bit press counter is provided for board LEDs and debug.

---
 rtl/btn_debounce_edge.sv | 84 ++++++++
 tb/tb_btn_debounce_edge.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce_edge.sv
`timescale 1ns/1ps
// Button conditioner: two-flop synchroniser, stability-count debouncer and
// registered rise/fall pulses, press toggle and 8-bit press counter.
module btn_debounce_edge #(
  parameter int STABLE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_in,
  output logic       db_out,
  output logic       rise_pulse,
  output logic       fall_pulse,
  output logic       toggle_out,
  output logic [7:0] press_cnt
);

  localparam int               CNT_W    = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             sync_1_reg;
  logic             sync_2_reg;
  logic [CNT_W-1:0] cnt_reg,    cnt_next;
  logic             db_reg,     db_next;
  logic             rise_reg,   rise_next;
  logic             fall_reg,   fall_next;
  logic             toggle_reg, toggle_next;
  logic [7:0]       press_reg,  press_next;

  // Only sync_2_reg feeds the debouncer; btn_in never reaches logic directly.
  always_comb begin
    cnt_next    = cnt_reg;
    db_next     = db_reg;
    rise_next   = 1'b0;
    fall_next   = 1'b0;
    toggle_next = toggle_reg;
    press_next  = press_reg;

    if (sync_2_reg == db_reg) begin
      cnt_next = '0;
    end else if (cnt_reg == CNT_LAST) begin
      cnt_next  = '0;
      db_next   = sync_2_reg;
      rise_next = sync_2_reg;
      fall_next = ~sync_2_reg;
    end else begin
      cnt_next = cnt_reg + CNT_W'(1);
    end

    // Toggle and press count follow accepted rises only, never falls.
    if (rise_next) begin
      toggle_next = ~toggle_reg;
      press_next  = press_reg + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1_reg <= 1'b0;
      sync_2_reg <= 1'b0;
      cnt_reg    <= '0;
      db_reg     <= 1'b0;
      rise_reg   <= 1'b0;
      fall_reg   <= 1'b0;
      toggle_reg <= 1'b0;
      press_reg  <= 8'h00;
    end else begin
      sync_1_reg <= btn_in;
      sync_2_reg <= sync_1_reg;
      cnt_reg    <= cnt_next;
      db_reg     <= db_next;
      rise_reg   <= rise_next;
      fall_reg   <= fall_next;
      toggle_reg <= toggle_next;
      press_reg  <= press_next;
    end
  end

  assign db_out     = db_reg;
  assign rise_pulse = rise_reg;
  assign fall_pulse = fall_reg;
  assign toggle_out = toggle_reg;
  assign press_cnt  = press_reg;

endmodule

// File: tb/tb_btn_debounce_edge.sv
`timescale 1ns/1ps
// Bench for btn_debounce_edge with STABLE_CYCLES=4: per-cycle table, level
// segments with latency-derived expectations, async reset and counter wrap.
module tb_btn_debounce_edge;

  localparam int STABLE = 4;
  // A new level held from edge 1 is accepted on edge STABLE+2 of its hold.
  localparam int LAT = STABLE + 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_in;
  logic       db_out;
  logic       rise_pulse;
  logic       fall_pulse;
  logic       toggle_out;
  logic [7:0] press_cnt;

  btn_debounce_edge #(.STABLE_CYCLES(STABLE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_in     (btn_in),
    .db_out     (db_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .toggle_out (toggle_out),
    .press_cnt  (press_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       db;
    logic       rise;
    logic       fall;
    logic       tog;
    logic [7:0] cnt;
  } exp_t;

  typedef struct {
    logic       rst;
    logic       btn;
    logic       db;
    logic       rise;
    logic       fall;
    logic       tog;
    logic [7:0] cnt;
  } vec_t;

  exp_t       sb_q[$];
  int         vectors     = 0;
  int         miscompares = 0;
  int         rise_seen   = 0;
  int         fall_seen   = 0;
  logic       m_db;
  logic       m_tog;
  logic [7:0] m_cnt;

  task automatic compare(input string name, input exp_t e);
    vectors++;
    if (db_out !== e.db || rise_pulse !== e.rise || fall_pulse !== e.fall ||
        toggle_out !== e.tog || press_cnt !== e.cnt) begin
      miscompares++;
      $display("FAIL %s: got db=%0b rise=%0b fall=%0b tog=%0b cnt=%02h, required db=%0b rise=%0b fall=%0b tog=%0b cnt=%02h",
               name, db_out, rise_pulse, fall_pulse, toggle_out, press_cnt,
               e.db, e.rise, e.fall, e.tog, e.cnt);
    end else begin
      $display("vec %0d %s: db=%0b rise=%0b fall=%0b tog=%0b cnt=%02h ok",
               vectors, name, db_out, rise_pulse, fall_pulse, toggle_out, press_cnt);
    end
  endtask

  task automatic check_int(input string name, input int got, input int req);
    vectors++;
    if (got != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end else begin
      $display("vec %0d %s: %0d ok", vectors, name, got);
    end
  endtask

  // Drive one cycle at the falling edge, queue its expectation, check after the rising edge.
  task automatic step(input string name, input logic r, input logic b, input exp_t e);
    exp_t got_e;
    @(negedge clk);
    rst_n  = r;
    btn_in = b;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (rise_pulse === 1'b1) rise_seen++;
    if (fall_pulse === 1'b1) fall_seen++;
    got_e = sb_q.pop_front();
    compare(name, got_e);
  endtask

  // Hold btn_in at lvl for n cycles; lengths 4..5 of a new level are never used.
  task automatic hold(input string name, input logic lvl, input int n);
    logic start_db;
    exp_t e;
    start_db = m_db;
    for (int i = 1; i <= n; i++) begin
      e.rise = 1'b0;
      e.fall = 1'b0;
      if (lvl != start_db && n >= LAT && i == LAT) begin
        m_db = lvl;
        if (lvl) begin
          e.rise = 1'b1;
          m_tog  = ~m_tog;
          m_cnt  = m_cnt + 8'd1;
        end else begin
          e.fall = 1'b1;
        end
      end
      e.db  = m_db;
      e.tog = m_tog;
      e.cnt = m_cnt;
      step(name, 1'b1, lvl, e);
    end
  endtask

  task automatic model_clear();
    m_db  = 1'b0;
    m_tog = 1'b0;
    m_cnt = 8'h00;
  endtask

  initial begin
    vec_t tbl[17];
    exp_t zero_e;
    exp_t e;

    tbl = '{
      '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00},
      '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00},
      '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00},
      '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00},
      '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00},
      '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00},
      '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00},
      '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00},
      '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h01},
      '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h01},
      '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h01},
      '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h01},
      '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h01},
      '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h01},
      '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h01},
      '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01},
      '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h01}
    };
    zero_e = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00};

    rst_n  = 1'b0;
    btn_in = 1'b1;

    // Reset with button held, rise after release, then a clean release.
    for (int i = 0; i < 17; i++) begin
      e = '{tbl[i].db, tbl[i].rise, tbl[i].fall, tbl[i].tog, tbl[i].cnt};
      step("table", tbl[i].rst, tbl[i].btn, e);
    end
    m_db  = 1'b0;
    m_tog = 1'b1;
    m_cnt = 8'h01;

    // Asynchronous reset part-way through a stable-high count.
    hold("rst_mid_pre", 1'b1, 3);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 compare("rst_immediate", zero_e);
    step("rst_held", 1'b0, 1'b1, zero_e);
    step("rst_held", 1'b0, 1'b1, zero_e);
    for (int i = 0; i < 8; i++) step("rst_released", 1'b1, 1'b0, zero_e);
    model_clear();

    hold("clean_press", 1'b1, 20);
    hold("clean_release", 1'b0, 20);

    hold("bounce", 1'b1, 2);
    hold("bounce", 1'b0, 2);
    hold("bounce", 1'b1, 2);
    hold("bounce", 1'b0, 2);
    hold("bounce_settle", 1'b1, 20);
    hold("bounce_release", 1'b0, 10);

    hold("glitch", 1'b1, 3);
    hold("glitch_after", 1'b0, 10);

    // Synchronous-style reset before the wrap run.
    step("wrap_rst", 1'b0, 1'b0, zero_e);
    step("wrap_rst", 1'b1, 1'b0, zero_e);
    step("wrap_rst", 1'b1, 1'b0, zero_e);
    model_clear();
    rise_seen = 0;
    fall_seen = 0;
    for (int p = 0; p < 256; p++) begin
      hold("wrap_press", 1'b1, LAT);
      hold("wrap_release", 1'b0, LAT);
    end
    check_int("wrap_rise_count", rise_seen, 256);
    check_int("wrap_fall_count", fall_seen, 256);
    check_int("wrap_press_cnt", int'(press_cnt), 0);
    check_int("wrap_toggle", int'(toggle_out), 0);
    check_int("scoreboard_drained", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
